tone_direction_decoder: RTL and testbench
=========================================

# tone_direction_decoder

Producer end of the tone-detection command interface consumed by the drive state machine. Samples the five asynchronous band-pass detector levels (bp1..bp5), qualifies a single clean tone, and presents a junction command as `tdEn`/`tdDir`. The drive state machine acknowledges the command with `tdAck`. After the command is released, the block ignores all tones until the channel has been quiet, so one long tone cannot issue a second command.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `QUAL_MS`, 20: a tone pattern must be stable this long to qualify. Also the required silence time.
- `ARM_WINDOW_MS`, 500: after the arm tone qualifies, a direction tone must qualify within this window.
- `HOLD_MS`, 2000: maximum time `tdEn` stays high without an ack.
- Derived values: `QUAL_CYC = CLK_FREQ/1000*QUAL_MS`, `ARM_CYC = CLK_FREQ/1000*ARM_WINDOW_MS`, `HOLD_CYC = CLK_FREQ/1000*HOLD_MS`. Counters are 32 bits and unsigned. Every derived count must be ≥1.
- `clk`  in  1  system clock. This is the only clock.
- `rstN`  in  1  synchronous, active-low reset.
- `bp1`..`bp5`  in  1 each  asynchronous detector levels. High means the tone is present.
  - `bp1` = STRAIGHT
  - `bp2` = LEFT
  - `bp3` = RIGHT
  - `bp4` = BACK
  - `bp5` = ARM
- `tdAck`  in  1  single-cycle consume strobe from the drive state machine.
- `tdEn`  out  1  command valid.
- `tdDir`  out  2  command direction:
  - 00 = STRAIGHT
  - 01 = LEFT
  - 10 = RIGHT
  - 11 = BACK
- `tdBusy`  out  1  high in every state except IDLE.

## Operation
- Each bp input passes through a 2-flop synchronizer, giving the 5-bit vector `s`.
- Stability counter `q`:
  - Resets to 0 whenever `s` differs from its value on the previous cycle.
  - Otherwise increments, saturating at `QUAL_CYC`.
  - `stable` = (`q == QUAL_CYC`).
- A pattern is qualified when `stable` is true and `s` is exactly one-hot. Zero bits set, or two or more bits set, never qualifies.
- States:
  - IDLE:
    - A qualified `bp5` goes to ARMED.
    - Qualified direction tones are ignored (only when the macro is enabled; see Configuration).
  - ARMED:
    - The window counter starts at 0 on entry.
    - A qualified direction tone goes to VALID. `tdDir` is loaded with the encoded tone and `tdEn` rises.
    - When the window counter reaches `ARM_CYC` with no qualified direction tone, go to QUIET.
    - A continuing `bp5`, or an invalid multi-tone pattern, keeps the state at ARMED; the window keeps running.
  - VALID:
    - The hold counter starts at 0 on entry.
    - `tdAck` goes to QUIET.
    - When the hold counter reaches `HOLD_CYC`, go to QUIET.
    - If ack and expiry occur in the same cycle, go to QUIET (single transition).
  - QUIET:
    - Go to IDLE once `s == 0` and `stable` are both true.
- `tdAck` is ignored outside VALID.
- `tdDir` holds its last value after `tdEn` falls. Its reset value is 00.
- Reset, including reset in the middle of an operation:
  - State returns to IDLE.
  - `tdEn` = 0, `tdDir` = 00, `tdBusy` = 0.
  - All counters and synchronizer flops are cleared to 0.

## Timing
- All outputs are registered.
- Qualification latency: if bpX is first captured by the first sync flop at edge E, `tdEn` is high after edge E+`QUAL_CYC`+2. Worked example: with `QUAL_CYC`=4, `tdEn` is high on the 7th cycle.
- `tdEn` falls on the cycle after the edge that samples `tdAck`.
- Hold expiry: `tdEn` is high for exactly `HOLD_CYC` cycles.
- ARMED lasts at most `ARM_CYC` cycles.
- `tdEn` and `tdDir` change only on state transitions. `tdDir` is updated in the same cycle `tdEn` rises.

## Configuration
- `TONE_ARM_EN` defined:
  - The arm sequence is required: IDLE→ARMED on `bp5`, then a direction tone.
  - A direction tone alone in IDLE is ignored.
- `TONE_ARM_EN` undefined:
  - ARMED is not built and `bp5` is ignored.
  - A one-hot pattern restricted to `s[3:0]` qualifies directly: IDLE→VALID.
  - All other states and timing are unchanged.

## Test plan
All scenarios use `CLK_FREQ`=1000, `QUAL_MS`=4, `ARM_WINDOW_MS`=20, `HOLD_MS`=50 (so 1 ms = 1 cycle).
- Reset: hold `rstN`=0 for 3 cycles with random bp activity → `tdEn`=0, `tdDir`=00, `tdBusy`=0 throughout and 1 cycle after release.
- `TONE_ARM_EN` defined:
  - Arm and command: `bp5` for 6 cycles, then `bp3` for 8 cycles → `tdEn` is high 7 cycles after `bp3` is first sampled, with `tdDir`=10. Pulse `tdAck` → `tdEn`=0 on the next cycle and `tdDir` stays 10. After 4 silent cycles → `tdBusy`=0.
  - Invalid pattern: arm, then `bp1`+`bp2` together for 15 cycles → `tdEn` never rises; state leaves ARMED at cycle 20 and `tdBusy` stays 1 until 4 silent cycles.
  - Timeout: arm, then `bp4`, with no ack → `tdEn` high for exactly 50 cycles, `tdDir`=11. With `bp4` still held, no new command is issued until `bp4` is removed.
  - Glitch rejection: after arming, `bp2` high for 3 cycles, low for 1, high for 3 → no `tdEn`.
- `TONE_ARM_EN` undefined:
  - `bp2` for 8 cycles → `tdEn`=1, `tdDir`=01.
  - Drive `rstN`=0 while `tdEn`=1 → `tdEn`=0 on the next cycle.

Source files
------------

// File: rtl/tone_direction_decoder.sv
// rtl/tone_direction_decoder.sv - qualifies band-pass tone levels into a tdEn/tdDir junction command
// Macro TONE_ARM_EN: require an arm tone (bp5) before a direction tone.
module tone_direction_decoder #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned QUAL_MS       = 20,
  parameter int unsigned ARM_WINDOW_MS = 500,
  parameter int unsigned HOLD_MS       = 2000
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  input  logic       tdAck,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic       tdBusy
);

  localparam logic [31:0] QUAL_CYC = 32'(CLK_FREQ / 1000 * QUAL_MS);
  localparam logic [31:0] HOLD_CYC = 32'(CLK_FREQ / 1000 * HOLD_MS);

  typedef enum logic [1:0] {IDLE, ARMED, VALID, QUIET} state_t;

  logic [4:0]  raw;
  logic [4:0]  sync1_q, s_q;
  logic [31:0] q_q, q_d;
  logic [31:0] hold_q;
  logic        stable, dir_hot, qual_dir;
  logic [1:0]  dir_code;
  state_t      state_q;

`ifdef TONE_ARM_EN
  localparam logic [31:0] ARM_CYC = 32'(CLK_FREQ / 1000 * ARM_WINDOW_MS);
  logic [31:0] win_q;
  logic        qual_arm;
  assign raw      = {bp5, bp4, bp3, bp2, bp1};
  assign qual_arm = stable && (s_q == 5'b10000);
`else
  localparam logic ARM_EN = 1'b0;
  assign raw = {bp5 & ARM_EN, bp4, bp3, bp2, bp1};
`endif

  // Change is detected one stage early so q is already 0 when s first shows a new pattern.
  always_comb begin
    q_d = q_q;
    if (sync1_q != s_q)
      q_d = 32'd0;
    else if (q_q != QUAL_CYC)
      q_d = q_q + 32'd1;
  end

  assign stable   = (q_q == QUAL_CYC);
  assign dir_hot  = ~s_q[4] && (s_q[3:0] != 4'b0000) &&
                    ((s_q[3:0] & (s_q[3:0] - 4'd1)) == 4'b0000);
  assign qual_dir = stable && dir_hot;

  always_comb begin
    dir_code = 2'b00;
    case (s_q[3:0])
      4'b0010: dir_code = 2'b01;
      4'b0100: dir_code = 2'b10;
      4'b1000: dir_code = 2'b11;
      default: dir_code = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1_q <= 5'b0;
      s_q     <= 5'b0;
      q_q     <= 32'd0;
      hold_q  <= 32'd0;
`ifdef TONE_ARM_EN
      win_q   <= 32'd0;
`endif
      state_q <= IDLE;
      tdEn    <= 1'b0;
      tdDir   <= 2'b00;
      tdBusy  <= 1'b0;
    end else begin
      sync1_q <= raw;
      s_q     <= sync1_q;
      q_q     <= q_d;
      case (state_q)
        IDLE: begin
`ifdef TONE_ARM_EN
          if (qual_arm) begin
            state_q <= ARMED;
            win_q   <= 32'd0;
            tdBusy  <= 1'b1;
          end
`else
          if (qual_dir) begin
            state_q <= VALID;
            hold_q  <= 32'd0;
            tdEn    <= 1'b1;
            tdDir   <= dir_code;
            tdBusy  <= 1'b1;
          end
`endif
        end
`ifdef TONE_ARM_EN
        ARMED: begin
          if (qual_dir) begin
            state_q <= VALID;
            hold_q  <= 32'd0;
            tdEn    <= 1'b1;
            tdDir   <= dir_code;
          end else if (win_q + 32'd1 == ARM_CYC) begin
            state_q <= QUIET;
          end else begin
            win_q <= win_q + 32'd1;
          end
        end
`endif
        VALID: begin
          if (tdAck || (hold_q + 32'd1 == HOLD_CYC)) begin
            state_q <= QUIET;
            tdEn    <= 1'b0;
          end else begin
            hold_q <= hold_q + 32'd1;
          end
        end
        QUIET: begin
          // Only a settled silence re-opens the channel; a held tone keeps us here.
          if ((s_q == 5'b0) && stable) begin
            state_q <= IDLE;
            tdBusy  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_direction_decoder.sv
// tb/tb_tone_direction_decoder.sv - table-driven scoreboard bench for tone_direction_decoder
module tb_tone_direction_decoder;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] bp;
  logic       tdAck;
  logic       tdEn;
  logic [1:0] tdDir;
  logic       tdBusy;

  int n_chk = 0;
  int n_err = 0;

  tone_direction_decoder #(
    .CLK_FREQ(1000),
    .QUAL_MS(4),
    .ARM_WINDOW_MS(20),
    .HOLD_MS(50)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .bp1(bp[0]),
    .bp2(bp[1]),
    .bp3(bp[2]),
    .bp4(bp[3]),
    .bp5(bp[4]),
    .tdAck(tdAck),
    .tdEn(tdEn),
    .tdDir(tdDir),
    .tdBusy(tdBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] bp;
    logic       ack;
    int         n;
    logic       each;
    logic       en;
    logic [1:0] dir;
    logic       busy;
    string      name;
  } vec_t;

  typedef struct {
    logic       en;
    logic [1:0] dir;
    logic       busy;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic void add(input logic [4:0] b, input logic a, input int n, input logic each,
                              input logic en, input logic [1:0] dir, input logic busy,
                              input string name);
    vec_t v;
    v.bp = b; v.ack = a; v.n = n; v.each = each;
    v.en = en; v.dir = dir; v.busy = busy; v.name = name;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic en, input logic [1:0] dir, input logic busy,
                            input string name);
    exp_t e;
    e.en = en; e.dir = dir; e.busy = busy; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    n_chk++;
    if (tdEn !== e.en || tdDir !== e.dir || tdBusy !== e.busy) begin
      n_err++;
      $display("FAIL %s: got en=%0b dir=%0b busy=%0b, expected en=%0b dir=%0b busy=%0b",
               e.name, tdEn, tdDir, tdBusy, e.en, e.dir, e.busy);
    end
  endtask

  initial begin
`ifdef TONE_ARM_EN
    // arm + bp3 command, ack, silence
    add(5'b10000, 0, 6, 1, 0, 2'b00, 0, "arm_pre");
    add(5'b00100, 0, 1, 0, 0, 2'b00, 1, "armed");
    add(5'b00100, 0, 5, 1, 0, 2'b00, 1, "bp3_pre");
    add(5'b00100, 0, 1, 0, 1, 2'b10, 1, "bp3_en");
    add(5'b00100, 1, 1, 0, 0, 2'b10, 1, "ack_drop");
    add(5'b00000, 0, 6, 1, 0, 2'b10, 1, "quiet_wait");
    add(5'b00000, 0, 1, 0, 0, 2'b10, 0, "idle_again");
    // invalid multi-tone while armed; window expires
    add(5'b10000, 0, 6, 0, 0, 2'b10, 0, "arm2_pre");
    add(5'b00011, 0, 15, 1, 0, 2'b10, 1, "two_tone_armed");
    add(5'b00000, 0, 6, 1, 0, 2'b10, 1, "two_tone_quiet");
    add(5'b00000, 0, 1, 0, 0, 2'b10, 0, "two_tone_idle");
    // timeout with bp4 held
    add(5'b10000, 0, 6, 0, 0, 2'b10, 0, "arm3_pre");
    add(5'b01000, 0, 6, 1, 0, 2'b10, 1, "bp4_pre");
    add(5'b01000, 0, 1, 0, 1, 2'b11, 1, "bp4_en");
    add(5'b01000, 0, 49, 1, 1, 2'b11, 1, "hold_high");
    add(5'b01000, 0, 1, 0, 0, 2'b11, 1, "hold_expire");
    add(5'b01000, 0, 20, 1, 0, 2'b11, 1, "no_recmd");
    add(5'b00000, 0, 6, 1, 0, 2'b11, 1, "bp4_off_wait");
    add(5'b00000, 0, 1, 0, 0, 2'b11, 0, "bp4_off_idle");
    // glitch rejection while armed
    add(5'b10000, 0, 6, 0, 0, 2'b11, 0, "arm4_pre");
    add(5'b00010, 0, 3, 1, 0, 2'b11, 1, "glitch_a");
    add(5'b00000, 0, 1, 1, 0, 2'b11, 1, "glitch_gap");
    add(5'b00010, 0, 3, 1, 0, 2'b11, 1, "glitch_b");
    add(5'b00000, 0, 14, 1, 0, 2'b11, 1, "glitch_window");
    add(5'b00000, 0, 1, 0, 0, 2'b11, 0, "glitch_idle");
    // direction alone is ignored in IDLE
    add(5'b00010, 0, 10, 1, 0, 2'b11, 0, "dir_no_arm");
    add(5'b00000, 0, 8, 0, 0, 2'b11, 0, "settle");
    // leave a live command for the mid-operation reset
    add(5'b10000, 0, 6, 0, 0, 2'b11, 0, "arm5_pre");
    add(5'b00001, 0, 7, 0, 1, 2'b00, 1, "bp1_en");
`else
    add(5'b00000, 0, 8, 1, 0, 2'b00, 0, "idle_quiet");
    add(5'b10000, 0, 10, 1, 0, 2'b00, 0, "bp5_ignored");
    add(5'b00000, 0, 8, 0, 0, 2'b00, 0, "settle0");
    add(5'b00010, 0, 6, 1, 0, 2'b00, 0, "bp2_pre");
    add(5'b00010, 0, 1, 0, 1, 2'b01, 1, "bp2_en");
    add(5'b00010, 1, 1, 0, 0, 2'b01, 1, "ack_drop");
    add(5'b00010, 0, 10, 1, 0, 2'b01, 1, "quiet_hold");
    add(5'b00000, 0, 6, 1, 0, 2'b01, 1, "quiet_pre");
    add(5'b00000, 0, 1, 0, 0, 2'b01, 0, "idle_again");
    add(5'b00000, 1, 3, 1, 0, 2'b01, 0, "ack_idle_ignored");
    add(5'b01000, 0, 6, 1, 0, 2'b01, 0, "bp4_pre");
    add(5'b01000, 0, 1, 0, 1, 2'b11, 1, "bp4_en");
    add(5'b01000, 0, 49, 1, 1, 2'b11, 1, "hold_high");
    add(5'b01000, 0, 1, 0, 0, 2'b11, 1, "hold_expire");
    add(5'b01000, 0, 20, 1, 0, 2'b11, 1, "no_recmd");
    add(5'b00000, 0, 6, 1, 0, 2'b11, 1, "bp4_off_wait");
    add(5'b00000, 0, 1, 0, 0, 2'b11, 0, "bp4_off_idle");
    add(5'b00011, 0, 15, 1, 0, 2'b11, 0, "two_tone");
    add(5'b00000, 0, 8, 0, 0, 2'b11, 0, "settle1");
    add(5'b00010, 0, 3, 1, 0, 2'b11, 0, "glitch_a");
    add(5'b00000, 0, 1, 1, 0, 2'b11, 0, "glitch_gap");
    add(5'b00010, 0, 3, 1, 0, 2'b11, 0, "glitch_b");
    add(5'b00000, 0, 8, 1, 0, 2'b11, 0, "glitch_after");
    add(5'b00001, 0, 7, 0, 1, 2'b00, 1, "bp1_en");
    add(5'b00001, 1, 1, 0, 0, 2'b00, 1, "ack1");
    add(5'b00000, 0, 7, 0, 0, 2'b00, 0, "idle3");
    add(5'b00100, 0, 7, 0, 1, 2'b10, 1, "bp3_en");
`endif

    rstN  = 1'b0;
    bp    = 5'b0;
    tdAck = 1'b0;

    // reset with random detector activity
    for (int i = 0; i < 3; i++) begin
      bp = 5'($urandom_range(0, 31));
      expect_out(1'b0, 2'b00, 1'b0, "reset_hold");
      tick();
      check_out();
    end
    rstN = 1'b1;
    bp   = 5'b0;
    expect_out(1'b0, 2'b00, 1'b0, "reset_release");
    tick();
    check_out();

    foreach (tbl[k]) begin
      bp    = tbl[k].bp;
      tdAck = tbl[k].ack;
      for (int i = 0; i < tbl[k].n; i++) begin
        if (tbl[k].each || i == tbl[k].n - 1)
          expect_out(tbl[k].en, tbl[k].dir, tbl[k].busy, tbl[k].name);
        tick();
        if (tbl[k].each || i == tbl[k].n - 1)
          check_out();
      end
    end
    tdAck = 1'b0;

    // reset while a command is live
    rstN = 1'b0;
    expect_out(1'b0, 2'b00, 1'b0, "reset_mid");
    tick();
    check_out();
    rstN = 1'b1;
    bp   = 5'b0;
    expect_out(1'b0, 2'b00, 1'b0, "reset_mid_release");
    tick();
    check_out();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
